// File: rtl/heaa_pkg.sv
// heaa_pkg: shared definitions for the HEAA adder family.
//   - Mode constants that describe how the inaccurate-bit count K is read.
//   - clamp_k: limits a requested K to the operand width.
//   - cnt_sat_max: all-ones saturation value for an error-event counter.
package heaa_pkg;

    // K = 0: the adder is fully exact.
    localparam int unsigned HEAA_K_EXACT    = 32'd0;
    // 0 < K < WIDTH: the low K bits are approximated; the carry from bit K-1 feeds the upper part.
    localparam int unsigned HEAA_K_MIN_APPX = 32'd1;
    // The legacy fixed-K adder used 12-bit operands and 9 inaccurate bits.
    localparam int unsigned HEAA_LEGACY_W   = 32'd12;
    localparam int unsigned HEAA_LEGACY_K   = 32'd9;

    // K values above the operand width behave as K = width.
    function automatic int unsigned clamp_k(input int unsigned k, input int unsigned width);
        if (k > width) begin
            return width;
        end else begin
            return k;
        end
    endfunction

    // Saturation value for a counter of cnt_w bits. Widths up to 32 bits are supported.
    function automatic logic [31:0] cnt_sat_max(input int unsigned cnt_w);
        if (cnt_w >= 32'd32) begin
            return 32'hFFFF_FFFF;
        end else begin
            return (32'd1 << cnt_w) - 32'd1;
        end
    endfunction

endpackage

// File: rtl/heaa_pipe_nb_chk.sv
// heaa_pipe_nb_chk: property checker for heaa_pipe_nb.
//   clk, rst_n : clock and asynchronous active-low reset
//   check_en   : high when the core output is about to be captured
//   approx     : approximate sum from the core
//   exact      : exact sum from the core
module heaa_pipe_nb_chk #(
    parameter int WIDTH = 12
) (
    input logic             clk,
    input logic             rst_n,
    input logic             check_en,
    input logic [WIDTH:0]   approx,
    input logic [WIDTH:0]   exact
);
    // A negative error distance would mean the approximation logic is broken.
    a_err_nonneg: assert property (@(posedge clk) disable iff (!rst_n)
        check_en |-> (exact >= approx));

endmodule

// File: rtl/heaa_var_core.sv
// heaa_var_core: combinational HEAA adder with a run-time inaccurate-bit count.
//   a, b    : WIDTH-bit unsigned operands
//   k       : inaccurate-bit count, already clamped to 0..WIDTH
//   approx  : approximate HEAA sum (WIDTH+1 bits)
//   exact   : exact sum a+b (WIDTH+1 bits)
// Bits below k-1 are a|b. Bit k-1 is a^b, and its a&b becomes the carry
// into the exact upper part. The approximation never exceeds the exact sum.
module heaa_var_core #(
    parameter int WIDTH = 12,
    parameter int KW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [KW-1:0]    k,
    output logic [WIDTH:0]   approx,
    output logic [WIDTH:0]   exact
);
    localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH:0] a_ext_s;
    logic [WIDTH:0] b_ext_s;
    logic [WIDTH:0] onehot_s;   // single bit at position k
    logic [WIDTH:0] top_s;      // single bit at k-1, or 0 when k = 0
    logic [WIDTH:0] or_mask_s;  // bits below k-1
    logic [WIDTH:0] carry_s;
    logic [WIDTH:0] upper_s;

    assign a_ext_s   = {1'b0, a};
    assign b_ext_s   = {1'b0, b};
    assign onehot_s  = ONE << k;
    assign top_s     = onehot_s >> 1;
    assign or_mask_s = (onehot_s - ONE) >> 1;

    // Mask selection takes care of k = 0: top_s is zero, so the carry is zero as well.
    assign carry_s = {{WIDTH{1'b0}}, |(a_ext_s & b_ext_s & top_s)};
    assign upper_s = (a_ext_s >> k) + (b_ext_s >> k) + carry_s;

    assign approx = (upper_s << k)
                  | ((a_ext_s | b_ext_s) & or_mask_s)
                  | ((a_ext_s ^ b_ext_s) & top_s);
    assign exact  = a_ext_s + b_ext_s;

endmodule

// File: rtl/heaa_pipe_nb.sv
// heaa_pipe_nb: two-stage pipelined HEAA adder with a per-transaction K.
//   clk, rst_n           : clock and asynchronous active-low reset
//   in_valid/in_ready    : input handshake; in_a, in_b operands; in_k inaccurate-bit count
//   out_valid/out_ready  : output handshake; out_sum approximate sum, out_err exact - approx
//   err_cnt              : saturating count of transferred results with a nonzero error
//   err_clr              : synchronous clear of err_cnt; wins over a same-cycle increment
// S1 registers the operands and the clamped K. S2 registers the core result.
module heaa_pipe_nb
    import heaa_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int KW    = $clog2(WIDTH + 1),
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    input  logic [KW-1:0]     in_k,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH:0]    out_sum,
    output logic [WIDTH:0]    out_err,
    output logic [CNT_W-1:0]  err_cnt,
    input  logic              err_clr
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_sat_max(CNT_W));
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             s1_valid_r;
    logic [WIDTH-1:0] s1_a_r;
    logic [WIDTH-1:0] s1_b_r;
    logic [KW-1:0]    s1_k_r;
    logic             s2_valid_r;
    logic [WIDTH:0]   out_sum_r;
    logic [WIDTH:0]   out_err_r;
    logic [CNT_W-1:0] err_cnt_r;
    logic             s2_advance_s;
    logic [WIDTH:0]   approx_s;
    logic [WIDTH:0]   exact_s;
    logic             err_xfer_s;

    assign s2_advance_s = !s2_valid_r || out_ready;
    assign in_ready     = !s1_valid_r || s2_advance_s;
    assign err_xfer_s   = s2_valid_r && out_ready && (out_err_r != '0);

    assign out_valid = s2_valid_r;
    assign out_sum   = out_sum_r;
    assign out_err   = out_err_r;
    assign err_cnt   = err_cnt_r;

    heaa_var_core #(
        .WIDTH (WIDTH),
        .KW    (KW)
    ) u_core (
        .a      (s1_a_r),
        .b      (s1_b_r),
        .k      (s1_k_r),
        .approx (approx_s),
        .exact  (exact_s)
    );

    heaa_pipe_nb_chk #(
        .WIDTH (WIDTH)
    ) u_chk (
        .clk      (clk),
        .rst_n    (rst_n),
        .check_en (s1_valid_r && s2_advance_s),
        .approx   (approx_s),
        .exact    (exact_s)
    );

    // S1: capture operands and the clamped K whenever the stage can move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= '0;
            s1_b_r     <= '0;
            s1_k_r     <= '0;
        end else if (in_ready) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_a_r <= in_a;
                s1_b_r <= in_b;
                s1_k_r <= KW'(clamp_k(32'(in_k), WIDTH));
            end
        end
    end

    // S2: register the core result; data holds while the output is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            out_sum_r  <= '0;
            out_err_r  <= '0;
        end else if (s2_advance_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                out_sum_r <= approx_s;
                out_err_r <= exact_s - approx_s;
            end
        end
    end

    // Error-event counter: clear first, otherwise count erroneous transfers up to saturation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_r <= '0;
        end else if (err_clr) begin
            err_cnt_r <= '0;
        end else if (err_xfer_s && (err_cnt_r != CNT_MAX)) begin
            err_cnt_r <= err_cnt_r + CNT_ONE;
        end
    end

endmodule
